idma_xif_ctrl: RTL and testbench

- Execution stage directly downstream of the iDMA Xif instruction decoder.
- Consumes decoded iDMA commands (configure / start / status) together with their register operands, and holds the per-transfer configuration.
- On start, issues one 2D transfer request to the iDMA frontend and returns a transfer ID as the instruction result.
- Tracks completions so that status queries and the outstanding-transfer limit are accurate.

---
 rtl/idma_xif_pkg.sv | 36 +++
 rtl/idma_xif_tf_tracker.sv | 59 +++++
 rtl/idma_xif_ctrl.sv | 135 +++++++++++++
 tb/tb_idma_xif_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_xif_pkg.sv
// Shared types for the iDMA Xif decoder and its execution stage.
package idma_xif_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned LenWidth  = 32;

  typedef enum logic [2:0] {
    CFG_SRC    = 3'd0,
    CFG_DST    = 3'd1,
    CFG_LEN    = 3'd2,
    CFG_STRIDE = 3'd3,
    CFG_REPS   = 3'd4,
    START      = 3'd5,
    STATUS     = 3'd6
  } idma_xif_op_e;

  typedef struct packed {
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [LenWidth-1:0]  len;
    logic [AddrWidth-1:0] src_stride;
    logic [AddrWidth-1:0] dst_stride;
    logic [LenWidth-1:0]  reps;
    logic                 dir;
  } idma_xif_req_t;

  // Next transfer ID of a width-bit counter; 0 is reserved, so the
  // all-ones value wraps to 1.
  function automatic logic [31:0] tf_id_next(input logic [31:0] id, input int unsigned width);
    logic [31:0] max_id;
    max_id = (32'd1 << width) - 32'd1;
    return (id >= max_id) ? 32'd1 : id + 32'd1;
  endfunction

endpackage

// File: rtl/idma_xif_tf_tracker.sv
// Tracks issued and completed transfer IDs and the number in flight.
module idma_xif_tf_tracker import idma_xif_pkg::*; #(
  parameter int unsigned TfIdWidth      = 8,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_i,
  input  logic                 done_i,
  output logic [TfIdWidth-1:0] next_id_o,
  output logic [TfIdWidth-1:0] done_id_o,
  output logic                 can_issue_o,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [TfIdWidth-1:0] next_id_q, next_id_d;
  logic [TfIdWidth-1:0] done_id_q, done_id_d;
  logic [CntWidth-1:0]  outstanding_q, outstanding_d;
  logic                 done_eff;

  // Counter next-state: a completion with nothing in flight is dropped.
  always_comb begin
    done_eff      = done_i && (outstanding_q != '0);
    next_id_d     = next_id_q;
    done_id_d     = done_id_q;
    outstanding_d = outstanding_q;
    if (issue_i) next_id_d = TfIdWidth'(tf_id_next(32'(next_id_q), TfIdWidth));
    if (done_eff) done_id_d = TfIdWidth'(tf_id_next(32'(done_id_q), TfIdWidth));
    if (issue_i && !done_eff) outstanding_d = outstanding_q + CntWidth'(1);
    else if (!issue_i && done_eff) outstanding_d = outstanding_q - CntWidth'(1);
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      next_id_q     <= TfIdWidth'(1);
      done_id_q     <= '0;
      outstanding_q <= '0;
    end else begin
      next_id_q     <= next_id_d;
      done_id_q     <= done_id_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign next_id_o   = next_id_q;
  assign done_id_o   = done_id_q;
  assign can_issue_o = outstanding_q < CntWidth'(MaxOutstanding);
  assign busy_o      = outstanding_q != '0;

  // A completion with nothing in flight means the frontend and tracker disagree.
  assert property (@(posedge clk_i) disable iff (rst_i) !(done_i && outstanding_q == '0))
    else $error("done_i received with no outstanding transfer");

endmodule

// File: rtl/idma_xif_ctrl.sv
// iDMA Xif execution stage: holds transfer config, issues 2D requests,
// and answers START/STATUS instructions with transfer IDs.
module idma_xif_ctrl import idma_xif_pkg::*; #(
  parameter int unsigned TfIdWidth      = 8,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  idma_xif_op_e         cmd_op_i,
  input  logic                 cmd_dir_i,
  input  logic [DataWidth-1:0] cmd_rs1_i,
  input  logic [DataWidth-1:0] cmd_rs2_i,
  input  logic [3:0]           cmd_id_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [DataWidth-1:0] res_data_o,
  output logic [3:0]           res_id_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output idma_xif_req_t        req_o,
  input  logic                 done_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam idma_xif_req_t CfgRst = '{
    src: '0, dst: '0, len: '0, src_stride: '0, dst_stride: '0,
    reps: LenWidth'(1), dir: 1'b0
  };

  state_e               state_q, state_d;
  idma_xif_req_t        cfg_q, cfg_d;
  idma_xif_req_t        req_q, req_d;
  logic [DataWidth-1:0] res_data_q, res_data_d;
  logic [3:0]           res_id_q, res_id_d;
  logic                 issue;
  logic                 can_issue;
  logic [TfIdWidth-1:0] next_id, done_id;

  idma_xif_tf_tracker #(
    .TfIdWidth     (TfIdWidth),
    .MaxOutstanding(MaxOutstanding)
  ) i_tracker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_i    (issue),
    .done_i     (done_i),
    .next_id_o  (next_id),
    .done_id_o  (done_id),
    .can_issue_o(can_issue),
    .busy_o     (busy_o)
  );

  // FSM next-state, config writes and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned and infers a latch.
    state_d     = state_q;
    cfg_d       = cfg_q;
    req_d       = req_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    cmd_ready_o = 1'b0;
    req_valid_o = 1'b0;
    res_valid_o = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = !rst_i && ((cmd_op_i != START) || can_issue);
        if (cmd_valid_i && cmd_ready_o) begin
          case (cmd_op_i)
            CFG_SRC: cfg_d.src = AddrWidth'(cmd_rs1_i);
            CFG_DST: cfg_d.dst = AddrWidth'(cmd_rs1_i);
            CFG_LEN: cfg_d.len = LenWidth'(cmd_rs1_i);
            CFG_STRIDE: begin
              cfg_d.src_stride = AddrWidth'(cmd_rs1_i);
              cfg_d.dst_stride = AddrWidth'(cmd_rs2_i);
            end
            CFG_REPS: cfg_d.reps = (cmd_rs1_i == '0) ? LenWidth'(1) : LenWidth'(cmd_rs1_i);
            START: begin
              req_d     = cfg_q;
              req_d.dir = cmd_dir_i;
              res_id_d  = cmd_id_i;
              state_d   = ISSUE;
            end
            STATUS: begin
              res_data_d = DataWidth'(done_id);
              res_id_d   = cmd_id_i;
              state_d    = RESP;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        req_valid_o = 1'b1;
        if (req_ready_i) begin
          issue      = 1'b1;
          res_data_d = DataWidth'(next_id);
          state_d    = RESP;
        end
      end
      RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, configuration and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cfg_q      <= CfgRst;
      req_q      <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      req_q      <= req_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign req_o      = req_q;
  assign res_data_o = res_data_q;
  assign res_id_o   = res_id_q;

endmodule

// File: tb/tb_idma_xif_ctrl.sv
// Scoreboard bench for idma_xif_ctrl.
module tb_idma_xif_ctrl;
  import idma_xif_pkg::*;

  localparam int TF = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  idma_xif_op_e         cmd_op_i;
  logic                 cmd_dir_i;
  logic [DataWidth-1:0] cmd_rs1_i;
  logic [DataWidth-1:0] cmd_rs2_i;
  logic [3:0]           cmd_id_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [DataWidth-1:0] res_data_o;
  logic [3:0]           res_id_o;
  logic                 req_valid_o;
  logic                 req_ready_i;
  idma_xif_req_t        req_o;
  logic                 done_i;
  logic                 busy_o;

  idma_xif_ctrl #(.TfIdWidth(TF), .MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_dir_i(cmd_dir_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i), .cmd_id_i(cmd_id_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_id_o(res_id_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_o(req_o),
    .done_i(done_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state and scoreboards.
  idma_xif_req_t m_cfg;
  int            m_next_id, m_done_id, m_out;
  idma_xif_req_t exp_req[$];
  logic [35:0]   exp_res[$];

  function automatic int wrap_id(input int id);
    return (id == (1 << TF) - 1) ? 1 : id + 1;
  endfunction

  function automatic void model_reset();
    m_cfg      = '0;
    m_cfg.reps = 32'd1;
    m_next_id  = 1;
    m_done_id  = 0;
    m_out      = 0;
    exp_req.delete();
    exp_res.delete();
  endfunction

  // Apply an accepted command to the model and queue what the DUT owes.
  function automatic void model_accept(input idma_xif_op_e op, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic dir, input logic [3:0] id);
    idma_xif_req_t r;
    case (op)
      CFG_SRC:    m_cfg.src = rs1;
      CFG_DST:    m_cfg.dst = rs1;
      CFG_LEN:    m_cfg.len = rs1;
      CFG_STRIDE: begin m_cfg.src_stride = rs1; m_cfg.dst_stride = rs2; end
      CFG_REPS:   m_cfg.reps = (rs1 == 0) ? 32'd1 : rs1;
      START: begin
        r = m_cfg; r.dir = dir;
        exp_req.push_back(r);
        exp_res.push_back({id, 32'(m_next_id)});
        m_next_id = wrap_id(m_next_id);
        m_out++;
      end
      STATUS: exp_res.push_back({id, 32'(m_done_id)});
      default: ;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send_cmd(input idma_xif_op_e op, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic dir, input logic [3:0] id);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_rs1_i = rs1; cmd_rs2_i = rs2;
    cmd_dir_i = dir; cmd_id_i = id;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 200) begin @(negedge clk_i); n++; end
    if (!cmd_ready_o) check("cmd_accept_timeout", 256'(cmd_ready_o), 256'(1));
    else model_accept(op, rs1, rs2, dir, id);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    while ((exp_res.size() != 0 || exp_req.size() != 0) && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    check("drain", 256'(exp_res.size() + exp_req.size()), 256'(0));
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    @(posedge clk_i); #1;
    done_i = 1'b0;
    if (m_out > 0) begin m_out--; m_done_id = wrap_id(m_done_id); end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    rst_i = 1'b0;
    model_reset();
  endtask

  // Scoreboard compare on each completed output handshake.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (req_valid_o && req_ready_i) begin
        if (exp_req.size() == 0) check("req_unexpected", 256'(1), 256'(0));
        else check("req", 256'(req_o), 256'(exp_req.pop_front()));
      end
      if (res_valid_o && res_ready_i) begin
        if (exp_res.size() == 0) check("res_unexpected", 256'(1), 256'(0));
        else check("res", 256'({res_id_o, res_data_o}), 256'(exp_res.pop_front()));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idma_xif_req_t exp_r, snap;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = CFG_SRC; cmd_dir_i = 1'b0;
    cmd_rs1_i = '0; cmd_rs2_i = '0; cmd_id_i = '0;
    res_ready_i = 1'b1; req_ready_i = 1'b1; done_i = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_cmd_ready", 256'(cmd_ready_o), 256'(0));
    check("rst_req_valid", 256'(req_valid_o), 256'(0));
    check("rst_res_valid", 256'(res_valid_o), 256'(0));
    check("rst_busy", 256'(busy_o), 256'(0));
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_cmd_ready", 256'(cmd_ready_o), 256'(1));
    @(posedge clk_i); #1;

    // Basic transfer and two-cycle result latency.
    send_cmd(CFG_SRC, 32'h1000, 0, 0, 4'd1);
    send_cmd(CFG_DST, 32'h2000, 0, 0, 4'd2);
    send_cmd(CFG_LEN, 32'd64, 0, 0, 4'd3);
    send_cmd(START, 0, 0, 1'b0, 4'd4);
    exp_r = '{src: 32'h1000, dst: 32'h2000, len: 32'd64, src_stride: 0, dst_stride: 0, reps: 32'd1, dir: 1'b0};
    @(negedge clk_i);
    check("t1_req", 256'(req_o), 256'(exp_r));
    check("t1_c1_res_valid", 256'(res_valid_o), 256'(0));
    check("t1_c1_cmd_ready", 256'(cmd_ready_o), 256'(0));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("t1_c2_res_valid", 256'(res_valid_o), 256'(1));
    check("t1_c2_res_data", 256'(res_data_o), 256'(1));
    check("t1_busy", 256'(busy_o), 256'(1));
    wait_res();

    // Reps of zero stored as one; stride operands.
    send_cmd(CFG_REPS, 0, 0, 0, 4'd5);
    send_cmd(CFG_STRIDE, 32'h40, 32'h80, 0, 4'd6);
    send_cmd(START, 0, 0, 1'b1, 4'd7);
    @(negedge clk_i);
    check("t2_reps", 256'(req_o.reps), 256'(1));
    check("t2_src_stride", 256'(req_o.src_stride), 256'(32'h40));
    check("t2_dst_stride", 256'(req_o.dst_stride), 256'(32'h80));
    check("t2_dir", 256'(req_o.dir), 256'(1));
    wait_res();

    // Frontend back-pressure holds the request stable.
    req_ready_i = 1'b0;
    send_cmd(CFG_REPS, 32'd3, 0, 0, 4'd8);
    send_cmd(START, 0, 0, 1'b0, 4'd9);
    @(negedge clk_i);
    snap = req_o;
    for (int i = 0; i < 5; i++) begin
      check("t3_req_valid", 256'(req_valid_o), 256'(1));
      check("t3_req_stable", 256'(req_o), 256'(snap));
      check("t3_cmd_ready", 256'(cmd_ready_o), 256'(0));
      @(posedge clk_i); #1;
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    req_ready_i = 1'b1;
    wait_res();

    // Result back-pressure holds result stable.
    res_ready_i = 1'b0;
    send_cmd(STATUS, 0, 0, 0, 4'hA);
    repeat (3) begin
      @(negedge clk_i);
      check("t3_res_hold_valid", 256'(res_valid_o), 256'(1));
      check("t3_res_hold_id", 256'(res_id_o), 256'(4'hA));
      @(posedge clk_i); #1;
    end
    res_ready_i = 1'b1;
    wait_res();

    // Outstanding limit: fifth START stalls until one completion.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_cmd(START, 0, 0, 1'b0, 4'(i));
      wait_res();
    end
    cmd_valid_i = 1'b1; cmd_op_i = START; cmd_dir_i = 1'b0; cmd_id_i = 4'hB;
    repeat (3) begin
      @(negedge clk_i);
      check("t4_stall", 256'(cmd_ready_o), 256'(0));
      @(posedge clk_i); #1;
    end
    done_i = 1'b1;
    @(negedge clk_i);
    check("t4_stall_done_cycle", 256'(cmd_ready_o), 256'(0));
    @(posedge clk_i); #1;
    done_i = 1'b0; m_out--; m_done_id = wrap_id(m_done_id);
    @(negedge clk_i);
    check("t4_unstall", 256'(cmd_ready_o), 256'(1));
    if (cmd_ready_o) model_accept(START, 0, 0, 1'b0, 4'hB);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("t4_id5", 256'(res_data_o), 256'(5));
    wait_res();
    send_cmd(STATUS, 0, 0, 0, 4'hC);
    @(negedge clk_i);
    check("t4_status", 256'(res_data_o), 256'(1));
    wait_res();

    // Completion coincident with an issue handshake.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_cmd(START, 0, 0, 1'b0, 4'(i));
      wait_res();
    end
    send_cmd(START, 0, 0, 1'b0, 4'd2);
    pulse_done();
    wait_res();
    check("t5_busy", 256'(busy_o), 256'(1));
    pulse_done();
    @(negedge clk_i);
    check("t5_busy_after1", 256'(busy_o), 256'(1));
    @(posedge clk_i); #1;
    pulse_done();
    @(negedge clk_i);
    check("t5_busy_after2", 256'(busy_o), 256'(0));
    @(posedge clk_i); #1;

    // ID wrap over 256 transfers.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_cmd(START, 0, 0, 1'b0, 4'(i));
      if (i >= 254) begin
        @(negedge clk_i);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("t6_wrap_id", 256'(res_data_o), 256'((i == 254) ? 255 : 1));
      end
      wait_res();
      pulse_done();
    end
    send_cmd(STATUS, 0, 0, 0, 4'hD);
    wait_res();

    // Reset while a request is pending.
    req_ready_i = 1'b0;
    send_cmd(START, 0, 0, 1'b0, 4'hE);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("t7_req_valid", 256'(req_valid_o), 256'(0));
    check("t7_res_valid", 256'(res_valid_o), 256'(0));
    check("t7_busy", 256'(busy_o), 256'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_ready_i = 1'b1;
    model_reset();
    send_cmd(STATUS, 0, 0, 0, 4'hF);
    @(negedge clk_i);
    check("t7_status", 256'(res_data_o), 256'(0));
    wait_res();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
